exception_dispatcher: RTL

//  Consumer side of exception capture: takes cause flags (bad opcode, overflow, div-by-zero),

---
 rtl/exception_dispatcher.sv | 111 +++++++++++
 1 files changed

// File: rtl/exception_dispatcher.sv
// Captures exception causes, saves EPC, fetches the handler vector byte and redirects the PC; RTE restores PC from EPC.
// Latency: cause to pc_wr is MEM_LAT+2 cycles, rte to pc_wr is 1 cycle; stall is held whenever a sequence is in flight.
module exception_dispatcher #(
    parameter logic [31:0] VEC_BASE  = 32'd253,
    parameter int          MEM_LAT   = 1,
    parameter logic [31:0] PC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flag_opcode,
    input  logic        flag_ovf,
    input  logic        flag_div0,
    input  logic        rte,
    input  logic [31:0] pc_in,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        pc_wr,
    output logic [31:0] pc_next,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic        in_handler,
    output logic        stall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT,
        S_LOAD,
        S_RET
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [7:0]  vec;
    logic        any_flag;
    logic [1:0]  flag_cause;

    assign any_flag   = flag_opcode | flag_ovf | flag_div0;
    assign flag_cause = flag_opcode ? 2'd0 : (flag_ovf ? 2'd1 : 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vec        <= '0;
            epc_out    <= '0;
            cause      <= '0;
            in_handler <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    // A new exception simply overwrites EPC/cause; there is no nesting.
                    if (any_flag) begin
                        epc_out    <= pc_in - PC_OFFSET;
                        cause      <= flag_cause;
                        in_handler <= 1'b1;
                        cnt        <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) vec <= mem_data;
                    else             cnt <= cnt - 4'd1;
                end
                S_RET:   in_handler <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        pc_wr     = 1'b0;
        pc_next   = '0;
        stall     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                // Exception beats a simultaneous rte; rte outside a handler is dropped.
                if (any_flag)                state_nxt = S_CAPTURE;
                else if (rte && in_handler)  state_nxt = S_RET;
            end
            S_CAPTURE: begin
                mem_rd    = 1'b1;
                mem_addr  = VEC_BASE + {30'd0, cause};
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pc_wr     = 1'b1;
                pc_next   = {24'd0, vec};
                state_nxt = S_IDLE;
            end
            S_RET: begin
                pc_wr     = 1'b1;
                pc_next   = epc_out;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
